// File: rtl/adc_temp_reader.sv
`default_nettype none
//============================================================================
// Module : adc_temp_reader
// ADC128S022 SPI master: round-robins thermistor channels, holds latest codes.
// Rev    : 1.0
//============================================================================
module adc_temp_reader #(
  parameter int CLK_DIV = 8,
  parameter int NUM_CH  = 2,
  parameter int GAP     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] temp0,
  output logic [11:0] temp1,
  output logic        sample_valid,
  output logic        sample_ch
);

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_START = 2'd1,
    ST_SHIFT = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_CH  = 3'(NUM_CH - 1);

  state_t      state_q;
  logic [15:0] gap_cnt_q;
  logic [7:0]  div_cnt_q;
  logic [3:0]  bit_cnt_q;
  logic        high_q;
  logic [15:0] cmd_q;
  logic [11:0] shift_q;
  logic [2:0]  next_addr_q;
  logic        prev_ch_q;
  logic        first_frame_q;
  logic        cs_n_q;
  logic        sclk_q;
  logic        din_q;
  logic [11:0] temp0_q;
  logic [11:0] temp1_q;
  logic        valid_q;
  logic        ch_q;

  logic [2:0]  next_addr_d;
  logic [15:0] cmd_d;

  assign next_addr_d = (next_addr_q == LAST_CH) ? 3'd0 : next_addr_q + 3'd1;
  assign cmd_d       = {2'b00, next_addr_q, 11'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_GAP;
      gap_cnt_q     <= '0;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      high_q        <= 1'b0;
      cmd_q         <= '0;
      shift_q       <= '0;
      next_addr_q   <= '0;
      prev_ch_q     <= 1'b0;
      first_frame_q <= 1'b1;
      cs_n_q        <= 1'b1;
      sclk_q        <= 1'b1;
      din_q         <= 1'b0;
      temp0_q       <= '0;
      temp1_q       <= '0;
      valid_q       <= 1'b0;
      ch_q          <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= '0;
            div_cnt_q <= '0;
            cmd_q     <= cmd_d;
            din_q     <= cmd_d[15];
            cs_n_q    <= 1'b0;
            state_q   <= ST_START;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end

        ST_START: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            high_q    <= 1'b0;
            sclk_q    <= 1'b0;
            din_q     <= cmd_q[15];
            cmd_q     <= {cmd_q[14:0], 1'b0};
            state_q   <= ST_SHIFT;
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end

        ST_SHIFT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            if (!high_q) begin
              // Only the last 12 bits survive; the leading nibble shifts out.
              sclk_q  <= 1'b1;
              high_q  <= 1'b1;
              shift_q <= {shift_q[10:0], adc_dout};
            end else if (bit_cnt_q == 4'd15) begin
              cs_n_q  <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              sclk_q    <= 1'b0;
              high_q    <= 1'b0;
              din_q     <= cmd_q[15];
              cmd_q     <= {cmd_q[14:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end

        ST_STOP: begin
          // The ADC pipelines by one frame: this data is for last frame's address.
          if (first_frame_q) begin
            first_frame_q <= 1'b0;
          end else begin
            if (prev_ch_q) temp1_q <= shift_q;
            else           temp0_q <= shift_q;
            valid_q <= 1'b1;
            ch_q    <= prev_ch_q;
          end
          prev_ch_q   <= next_addr_q[0];
          next_addr_q <= next_addr_d;
          state_q     <= ST_GAP;
        end

        default: state_q <= ST_GAP;
      endcase
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_din      = din_q;
  assign temp0        = temp0_q;
  assign temp1        = temp1_q;
  assign sample_valid = valid_q;
  assign sample_ch    = ch_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_temp_reader.sv
`default_nettype none
//============================================================================
// Module : tb_adc_temp_reader
// Bench for adc_temp_reader with behavioural ADC128S022 models.
// Rev    : 1.0
//============================================================================
module tb_adc_temp_reader;

  localparam int A_DIV = 2;
  localparam int A_GAP = 4;
  localparam int B_DIV = 3;
  localparam int B_GAP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  logic a_cs_n, a_sclk, a_din, a_sv, a_sch;
  logic b_cs_n, b_sclk, b_din, b_sv, b_sch;
  logic a_dout = 1'b0;
  logic b_dout = 1'b0;
  logic [11:0] a_t0, a_t1, b_t0, b_t1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ch  = 0;

  adc_temp_reader #(.CLK_DIV(A_DIV), .NUM_CH(2), .GAP(A_GAP)) u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .adc_cs_n(a_cs_n), .adc_sclk(a_sclk),
    .adc_din(a_din), .adc_dout(a_dout), .temp0(a_t0), .temp1(a_t1),
    .sample_valid(a_sv), .sample_ch(a_sch));

  adc_temp_reader #(.CLK_DIV(B_DIV), .NUM_CH(1), .GAP(B_GAP)) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .adc_cs_n(b_cs_n), .adc_sclk(b_sclk),
    .adc_din(b_din), .adc_dout(b_dout), .temp0(b_t0), .temp1(b_t1),
    .sample_valid(b_sv), .sample_ch(b_sch));

  // ADC model A: per-channel "analog" value; returns the previous frame's address.
  logic [11:0] a_val [8];
  logic [3:0]  a_nib = 4'h0;
  logic [15:0] a_word = '0;
  logic [15:0] a_rx = '0;
  logic [2:0]  a_conv = 3'd0;
  int          a_rise = 0;
  int          a_addr_q[$];

  always @(negedge a_cs_n) begin
    a_word = {a_nib, a_val[a_conv]};
    a_rise = 0;
    a_rx   = '0;
  end
  always @(negedge a_sclk) if (a_cs_n === 1'b0) begin
    a_dout <= a_word[15];
    a_word = {a_word[14:0], 1'b0};
  end
  always @(posedge a_sclk) if (a_cs_n === 1'b0) begin
    a_rx = {a_rx[14:0], a_din};
    a_rise++;
  end
  always @(posedge a_cs_n) if (a_rise == 16) begin
    a_conv = a_rx[13:11];
    a_addr_q.push_back(int'(a_rx[13:11]));
  end

  logic [11:0] b_val [8];
  logic [3:0]  b_nib = 4'h0;
  logic [15:0] b_word = '0;
  logic [15:0] b_rx = '0;
  logic [2:0]  b_conv = 3'd0;
  int          b_rise = 0;
  int          b_addr_q[$];

  always @(negedge b_cs_n) begin
    b_word = {b_nib, b_val[b_conv]};
    b_rise = 0;
    b_rx   = '0;
  end
  always @(negedge b_sclk) if (b_cs_n === 1'b0) begin
    b_dout <= b_word[15];
    b_word = {b_word[14:0], 1'b0};
  end
  always @(posedge b_sclk) if (b_cs_n === 1'b0) begin
    b_rx = {b_rx[14:0], b_din};
    b_rise++;
  end
  always @(posedge b_cs_n) if (b_rise == 16) begin
    b_conv = b_rx[13:11];
    b_addr_q.push_back(int'(b_rx[13:11]));
  end

  // Pulse/stability monitors: record updates, flag long pulses and silent changes.
  int a_ev_ch[$], a_ev_val[$], b_ev_ch[$], b_ev_val[$];
  int a_long = 0, a_glitch = 0, b_long = 0, b_glitch = 0;
  logic a_sv_p = 1'b0, b_sv_p = 1'b0;
  logic [11:0] a_t0_p = '0, a_t1_p = '0, b_t0_p = '0, b_t1_p = '0;

  always @(negedge clk) begin
    if (rst_a_n === 1'b1) begin
      if (a_sv) begin
        a_ev_ch.push_back(int'(a_sch));
        a_ev_val.push_back(int'(a_sch ? a_t1 : a_t0));
        if (a_sv_p) a_long++;
      end
      if (a_t0 !== a_t0_p && !(a_sv && !a_sch)) a_glitch++;
      if (a_t1 !== a_t1_p && !(a_sv && a_sch))  a_glitch++;
    end
    if (rst_b_n === 1'b1) begin
      if (b_sv) begin
        b_ev_ch.push_back(int'(b_sch));
        b_ev_val.push_back(int'(b_sch ? b_t1 : b_t0));
        if (b_sv_p) b_long++;
      end
      if (b_t0 !== b_t0_p && !(b_sv && !b_sch)) b_glitch++;
      if (b_t1 !== b_t1_p && !(b_sv && b_sch))  b_glitch++;
    end
    a_sv_p = a_sv; a_t0_p = a_t0; a_t1_p = a_t1;
    b_sv_p = b_sv; b_t0_p = b_t0; b_t1_p = b_t1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames_a(input int n);
    int target;
    int i;
    target = a_addr_q.size() + n;
    i = 0;
    while (a_addr_q.size() < target && i < 200 * n) begin cyc(1); i++; end
    if (a_addr_q.size() < target) begin
      n_tests++; n_fail++;
      $display("FAIL wait_frames_a: frames %0d, required %0d", a_addr_q.size(), target);
    end
  endtask

  task automatic wait_frames_b(input int n);
    int target;
    int i;
    target = b_addr_q.size() + n;
    i = 0;
    while (b_addr_q.size() < target && i < 300 * n) begin cyc(1); i++; end
    if (b_addr_q.size() < target) begin
      n_tests++; n_fail++;
      $display("FAIL wait_frames_b: frames %0d, required %0d", b_addr_q.size(), target);
    end
  endtask

  task automatic clear_a_events();
    a_ev_ch.delete();
    a_ev_val.delete();
  endtask

  task automatic test_reset();
    int cnt;
    cyc(3);
    n_tests++; if (a_cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %b, expected 1", a_cs_n); end
    n_tests++; if (a_sclk !== 1'b1) begin n_fail++; $display("FAIL rst_sclk: got %b, expected 1", a_sclk); end
    n_tests++; if (a_din !== 1'b0) begin n_fail++; $display("FAIL rst_din: got %b, expected 0", a_din); end
    n_tests++; if (a_t0 !== 12'h000) begin n_fail++; $display("FAIL rst_temp0: got %h, expected 000", a_t0); end
    n_tests++; if (a_t1 !== 12'h000) begin n_fail++; $display("FAIL rst_temp1: got %h, expected 000", a_t1); end
    n_tests++; if (a_sv !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", a_sv); end
    n_tests++; if (a_sch !== 1'b0) begin n_fail++; $display("FAIL rst_ch: got %b, expected 0", a_sch); end
    @(negedge clk) rst_b_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1); cnt++;
      if (b_cs_n === 1'b0) break;
    end
    n_tests++; if (cnt != B_GAP) begin n_fail++; $display("FAIL rst_gap_cycles: got %0d, expected %0d", cnt, B_GAP); end
  endtask

  task automatic test_timing();
    int fall1, fall2, low, sfalls;
    logic prev_cs, prev_sclk;
    a_val[0] = 12'hABC; a_val[1] = 12'h123; a_nib = 4'h0;
    @(negedge clk) rst_a_n = 1'b1;
    fall1 = -1; fall2 = -1; low = 0; sfalls = 0; prev_cs = 1'b1; prev_sclk = 1'b1;
    for (int i = 0; i < 400 && fall2 < 0; i++) begin
      cyc(1);
      if (prev_cs && !a_cs_n) begin
        if (fall1 < 0) fall1 = i; else fall2 = i;
      end
      if (fall2 < 0 && fall1 >= 0 && !a_cs_n) begin
        low++;
        if (prev_sclk && !a_sclk) sfalls++;
      end
      prev_cs = a_cs_n; prev_sclk = a_sclk;
    end
    n_tests++; if (low != 33 * A_DIV) begin n_fail++; $display("FAIL cs_low_cycles: got %0d, expected %0d", low, 33 * A_DIV); end
    n_tests++; if (sfalls != 16) begin n_fail++; $display("FAIL sclk_falls: got %0d, expected 16", sfalls); end
    n_tests++; if (fall2 - fall1 != A_GAP + 33 * A_DIV + 1) begin
      n_fail++; $display("FAIL frame_period: got %0d, expected %0d", fall2 - fall1, A_GAP + 33 * A_DIV + 1);
    end
    wait_frames_a(3 - a_addr_q.size());
    n_tests++; if (a_addr_q.size() < 3 || a_addr_q[0] != 0 || a_addr_q[1] != 1 || a_addr_q[2] != 0) begin
      n_fail++; $display("FAIL din_addr_seq: got %p, expected 0,1,0", a_addr_q);
    end
  endtask

  task automatic test_datapath();
    cyc(2);
    n_tests++; if (a_ev_ch.size() != 2) begin n_fail++; $display("FAIL dp_pulse_count: got %0d, expected 2", a_ev_ch.size()); end
    if (a_ev_ch.size() >= 2) begin
      n_tests++; if (a_ev_ch[0] != 0 || a_ev_val[0] != 'hABC) begin
        n_fail++; $display("FAIL dp_frame2: got ch%0d %h, expected ch0 abc", a_ev_ch[0], a_ev_val[0]);
      end
      n_tests++; if (a_ev_ch[1] != 1 || a_ev_val[1] != 'h123) begin
        n_fail++; $display("FAIL dp_frame3: got ch%0d %h, expected ch1 123", a_ev_ch[1], a_ev_val[1]);
      end
    end
    n_tests++; if (a_t0 !== 12'hABC || a_t1 !== 12'h123) begin
      n_fail++; $display("FAIL dp_temps: got %h/%h, expected abc/123", a_t0, a_t1);
    end
    exp_ch = 0;
  endtask

  task automatic test_leading_bits();
    a_nib = 4'hF; a_val[0] = 12'h5A5; a_val[1] = 12'hA5A;
    clear_a_events();
    wait_frames_a(2); cyc(2);
    n_tests++; if (a_ev_ch.size() != 2 || a_ev_ch[0] != 0 || a_ev_val[0] != 'h5A5 || a_ev_val[1] != 'hA5A) begin
      n_fail++; $display("FAIL leading_bits: got %p / %p, expected ch0 5a5 then a5a", a_ev_ch, a_ev_val);
    end
    n_tests++; if (a_t0 !== 12'h5A5) begin n_fail++; $display("FAIL leading_temp0: got %h, expected 5a5", a_t0); end
    exp_ch = 0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 8; c++) a_val[c] = 12'($urandom_range(1, 4095));
      a_nib = 4'($urandom);
      clear_a_events();
      wait_frames_a(2); cyc(2);
      n_tests++; if (a_ev_ch.size() != 2) begin
        n_fail++; $display("FAIL rand_pulses r%0d: got %0d, expected 2", r, a_ev_ch.size());
      end
      for (int k = 0; k < 2 && k < a_ev_ch.size(); k++) begin
        n_tests++; if (a_ev_ch[k] != exp_ch || a_ev_val[k] != int'(a_val[exp_ch])) begin
          n_fail++; $display("FAIL rand_update r%0d k%0d: got ch%0d %h, expected ch%0d %h",
                             r, k, a_ev_ch[k], a_ev_val[k], exp_ch, a_val[exp_ch]);
        end
        exp_ch = (exp_ch + 1) % 2;
      end
      n_tests++; if (a_t0 !== a_val[0] || a_t1 !== a_val[1]) begin
        n_fail++; $display("FAIL rand_temps r%0d: got %h/%h, expected %h/%h", r, a_t0, a_t1, a_val[0], a_val[1]);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int i;
    i = 0;
    while (a_cs_n !== 1'b0 && i < 200) begin cyc(1); i++; end
    while (!(a_rise == 7 && a_sclk === 1'b0) && i < 400) begin cyc(1); i++; end
    n_tests++; if (a_rise != 7 || a_cs_n !== 1'b0) begin
      n_fail++; $display("FAIL mid_reach: got rise %0d cs_n %b, expected 7 and 0", a_rise, a_cs_n);
    end
    #2 rst_a_n = 1'b0;
    #1;
    n_tests++; if (a_cs_n !== 1'b1 || a_sclk !== 1'b1) begin
      n_fail++; $display("FAIL mid_async: got cs_n %b sclk %b, expected 1 1", a_cs_n, a_sclk);
    end
    n_tests++; if (a_t0 !== 12'h000 || a_t1 !== 12'h000) begin
      n_fail++; $display("FAIL mid_temps: got %h/%h, expected 000/000", a_t0, a_t1);
    end
    cyc(2);
    for (int c = 0; c < 8; c++) a_val[c] = 12'($urandom_range(1, 4095));
    a_nib = 4'($urandom);
    @(negedge clk) rst_a_n = 1'b1;
    clear_a_events();
    wait_frames_a(1); cyc(2);
    n_tests++; if (a_ev_ch.size() != 0) begin n_fail++; $display("FAIL mid_first_discard: got %0d pulses, expected 0", a_ev_ch.size()); end
    n_tests++; if (a_addr_q[$] != 0) begin n_fail++; $display("FAIL mid_first_addr: got %0d, expected 0", a_addr_q[$]); end
    wait_frames_a(1); cyc(2);
    n_tests++; if (a_ev_ch.size() != 1 || a_ev_ch[0] != 0 || a_ev_val[0] != int'(a_val[0])) begin
      n_fail++; $display("FAIL mid_second: got %p / %p, expected ch0 %h", a_ev_ch, a_ev_val, a_val[0]);
    end
    n_tests++; if (a_t1 !== 12'h000) begin n_fail++; $display("FAIL mid_temp1: got %h, expected 000", a_t1); end
  endtask

  task automatic test_num_ch1();
    int bad;
    wait_frames_b(2); cyc(2);
    bad = 0;
    foreach (b_addr_q[i]) if (b_addr_q[i] != 0) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL ch1_addr: got %0d nonzero addresses, expected 0", bad); end
    n_tests++; if (b_ev_ch.size() != b_addr_q.size() - 1) begin
      n_fail++; $display("FAIL ch1_pulses: got %0d, expected %0d", b_ev_ch.size(), b_addr_q.size() - 1);
    end
    bad = 0;
    foreach (b_ev_ch[i]) if (b_ev_ch[i] != 0 || b_ev_val[i] != int'(b_val[0])) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL ch1_updates: got %0d wrong updates, expected 0", bad); end
    n_tests++; if (b_t0 !== b_val[0] || b_t1 !== 12'h000) begin
      n_fail++; $display("FAIL ch1_temps: got %h/%h, expected %h/000", b_t0, b_t1, b_val[0]);
    end
  endtask

  task automatic test_monitors();
    n_tests++; if (a_long != 0 || b_long != 0) begin
      n_fail++; $display("FAIL pulse_width: got %0d/%0d long pulses, expected 0", a_long, b_long);
    end
    n_tests++; if (a_glitch != 0 || b_glitch != 0) begin
      n_fail++; $display("FAIL temp_stable: got %0d/%0d silent changes, expected 0", a_glitch, b_glitch);
    end
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a_val[c] = 12'h000;
      b_val[c] = 12'($urandom_range(1, 4095));
    end
    b_nib = 4'($urandom);
    test_reset();
    test_timing();
    test_datapath();
    test_leading_bits();
    test_random();
    test_reset_mid_shift();
    test_num_ch1();
    test_monitors();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_temp_reader.md
Name: adc_temp_reader

Overview:
SPI master for the board's ADC128S022 (8-ch, 12-bit serial ADC). It round-robins over thermistor channels and holds the latest raw 12-bit code per channel. The block sits directly upstream of the heater controllers: temp0 drives the hotend controller's temp input and temp1 drives the bed controller's temp input. Both controllers apply their own filtering; this block does no averaging.

Parameters:
CLK_DIV, 8, clk cycles per SCLK half-period (legal 2..255)
NUM_CH, 2, channels scanned, 0..NUM_CH-1 (legal 1..2)
GAP, 16, idle clk cycles with CS_n high between frames (legal 1..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
adc_cs_n  out  1  ADC chip select, active low
adc_sclk  out  1  ADC serial clock, idles high
adc_din  out  1  ADC DIN, carries the address of the next conversion
adc_dout  in  1  ADC DOUT, conversion data
temp0  out  12  latest code, channel 0 (hotend)
temp1  out  12  latest code, channel 1 (bed); held at reset value when NUM_CH=1
sample_valid  out  1  one-clk pulse when temp0 or temp1 is updated
sample_ch  out  1  channel index of the update flagged by sample_valid

Behaviour:
- Reset (async assert, sync release), all outputs: adc_cs_n=1, adc_sclk=1, adc_din=0, temp0=temp1=12'h000, sample_valid=0, sample_ch=0, FSM=GAP, first_frame=1, next_addr=0.
- 12'h000 is the "hot" code, so downstream heaters stay off until real data arrives.
- FSM states: GAP -> START -> SHIFT -> STOP -> GAP.
- GAP: CS_n=1, SCLK=1. Counts GAP cycles, then enters START.
- START: CS_n=0, SCLK=1. adc_din = bit15 of the command word. Holds CLK_DIV cycles.
- SHIFT: 16 SCLK periods, each a low phase (CLK_DIV cycles) then a high phase (CLK_DIV cycles).
  - Command word, MSB first: {2'b00, addr[2:0], 11'b0}, where addr = current next_addr.
  - adc_din changes only on the clk edge that drives SCLK 1->0.
  - adc_dout is sampled on the clk edge that drives SCLK 0->1, then shifted into a 16-bit register, MSB first.
- STOP (1 cycle): CS_n=1, SCLK=1.
  - The result is shift[11:0]. Bits 15:12 are ignored, even if nonzero.
  - The result belongs to prev_addr, the address sent in the previous frame (the ADC pipelines conversions by one frame).
  - If first_frame=1: discard the result, clear first_frame, no pulse.
  - Otherwise: write the result to temp[prev_addr], pulse sample_valid for 1 cycle, set sample_ch=prev_addr.
  - Then prev_addr<=next_addr and next_addr<=(next_addr+1) mod NUM_CH.
- Frame period: GAP + CLK_DIV + 32*CLK_DIV + 1 clk cycles. CS_n low for exactly 33*CLK_DIV cycles.
- temp0/temp1 change only in STOP and are otherwise stable, so consumers sample without a handshake.
- NUM_CH=1: every frame addresses channel 0 and temp1 never changes.
- Reset mid-frame: CS_n returns high and SCLK high immediately (async). The partial frame is dropped and temps clear to 0. The first frame after release is discarded again.
- No back-pressure. Consumers that miss a sample_valid pulse still see the held value.

Test Plan:
- Reset: hold rst_n=0 -> cs_n=1, sclk=1, temp0=temp1=0, sample_valid=0. Deassert -> cs_n stays high for GAP=16 cycles, then falls.
- Timing (CLK_DIV=2, GAP=4): cs_n low for 66 clk, exactly 16 SCLK falling edges, frame period 71 clk. DIN bits 13..11 = 000 in frame 1, 001 in frame 2, 000 in frame 3.
- Data path: ADC model returns 0x0ABC for ch0 and 0x0123 for ch1. Results:
  - Frame 1: no pulse.
  - Frame 2: temp0=0xABC, sample_ch=0.
  - Frame 3: temp1=0x123, sample_ch=1.
  - Each update comes with a single 1-cycle sample_valid pulse.
- Leading bits: model drives 4'b1111 before 0x5A5 -> temp=0x5A5, upper bits ignored.
- Reset mid-SHIFT, after 7 SCLK periods -> cs_n=1 in the same cycle, temps=0. The next completed frame gives no pulse, and the following frame updates ch0.
- NUM_CH=1: DIN address is always 000 and temp0 updates every frame after the first. temp1 stays 0.
